// File: rtl/pfpu_pkg.sv
// Shared definitions for the PFPU program loader.
//   PFPU_AW / PFPU_DW : program address and instruction word widths
//   *_MSB             : field boundaries inside a 25-bit instruction word
//                       (a:7 | b:7 | opcode:4 | w:7)
//   PFPU_OFFS_W       : width of the in-page offset on the control interface
//   ld_state_e        : loader FSM state encoding
package pfpu_pkg;

  localparam int PFPU_AW     = 11;
  localparam int PFPU_DW     = 25;
  localparam int PFPU_OFFS_W = 9;

  localparam int A_MSB  = 24;
  localparam int B_MSB  = 17;
  localparam int OP_MSB = 10;
  localparam int W_MSB  = 6;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_WRITE  = 3'd1,
    LD_RDADDR = 3'd2,
    LD_CMP    = 3'd3,
    LD_FINISH = 3'd4
  } ld_state_e;

endpackage

// File: rtl/pfpu_prog_loader.sv
// Host-side writer for the PFPU program memory control interface.
// Streams instruction words into consecutive program addresses from a base,
// optionally reading each word back and aborting on the first mismatch.
//
// State table:
//   LD_IDLE   | waiting for start; control interface released (c_en=0)
//   LD_WRITE  | accept a word and write it at addr
//   LD_RDADDR | present addr for read-back (memory is registered)
//   LD_CMP    | compare read data with the held word
//   LD_FINISH | one-cycle done pulse, then release the interface
//
// Ports:
//   sys_clk, sys_rst           : clock, async active-high reset
//   start, base, len, verify   : session request, sampled in IDLE only
//   s_valid, s_ready, s_data   : instruction word stream
//   c_en, c_page, c_offset,
//   c_di, c_w_en, c_do         : program memory control interface
//   busy, done, error, err_addr: session status
module pfpu_prog_loader
  import pfpu_pkg::*;
#(
  parameter int AW = PFPU_AW,
  parameter int DW = PFPU_DW
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         start,
  input  logic [AW-1:0]                base,
  input  logic [AW:0]                  len,
  input  logic                         verify,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DW-1:0]                s_data,
  output logic                         c_en,
  output logic [AW-PFPU_OFFS_W-1:0]    c_page,
  output logic [PFPU_OFFS_W-1:0]       c_offset,
  output logic [31:0]                  c_di,
  output logic                         c_w_en,
  input  logic [31:0]                  c_do,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [AW-1:0]                err_addr
);

  ld_state_e         state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW:0]       remaining_q, remaining_d;
  logic              vmode_q, vmode_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic              error_q, error_d;
  logic [AW-1:0]     err_addr_q, err_addr_d;
  logic [AW-1:0]     c_addr;
  logic              last_word;

  // Upper read-data bits carry nothing for a 25-bit program word.
  logic unused_c_do;
  assign unused_c_do = ^c_do[31:DW];

  assign last_word = (remaining_q == (AW+1)'(1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= LD_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      vmode_q     <= 1'b0;
      hold_q      <= '0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      vmode_q     <= vmode_d;
      hold_q      <= hold_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    vmode_d     = vmode_q;
    hold_d      = hold_q;
    error_d     = error_q;
    err_addr_d  = err_addr_q;
    s_ready     = 1'b0;
    c_en        = 1'b0;
    c_w_en      = 1'b0;
    c_addr      = '0;
    c_di        = '0;
    done        = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (start) begin
          addr_d      = base;
          remaining_d = len;
          vmode_d     = verify;
          error_d     = 1'b0;
          err_addr_d  = '0;
          state_d     = (len == '0) ? LD_FINISH : LD_WRITE;
        end
      end

      LD_WRITE: begin
        c_en    = 1'b1;
        s_ready = 1'b1;
        c_addr  = addr_q;
        c_di    = {{(32-DW){1'b0}}, s_data};
        c_w_en  = s_valid;
        if (s_valid) begin
          hold_d = s_data;
          if (vmode_q) begin
            state_d = LD_RDADDR;
          end else begin
            // addr wraps modulo 2^AW by width truncation
            addr_d      = addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
            if (last_word) state_d = LD_FINISH;
          end
        end
      end

      LD_RDADDR: begin
        c_en    = 1'b1;
        c_addr  = addr_q;
        state_d = LD_CMP;
      end

      LD_CMP: begin
        c_en   = 1'b1;
        c_addr = addr_q;
        if (c_do[DW-1:0] != hold_q) begin
          error_d    = 1'b1;
          err_addr_d = addr_q;
          state_d    = LD_FINISH;
        end else begin
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = last_word ? LD_FINISH : LD_WRITE;
        end
      end

      LD_FINISH: begin
        c_en    = 1'b1;
        c_addr  = addr_q;
        done    = 1'b1;
        state_d = LD_IDLE;
      end

      default: state_d = LD_IDLE;
    endcase
  end

  assign c_page   = c_addr[AW-1:PFPU_OFFS_W];
  assign c_offset = c_addr[PFPU_OFFS_W-1:0];
  assign busy     = (state_q != LD_IDLE);
  assign error    = error_q;
  assign err_addr = err_addr_q;

endmodule
